// File: rtl/tone_scheduler.sv
// -----------------------------------------------------------------------------
// tone_scheduler
//
// Queues note requests from four debounced buttons and plays them one at a
// time on a piezo buzzer. Each note is a square wave lasting NOTE_CYCLES clocks.
// A silent gap of GAP_CYCLES clocks follows each note.
//
// Build option:
//   TONE_SCHED_RR_EN  defined   -> round-robin arbitration between pending notes
//                     undefined -> fixed priority, req[0] highest
//
// Ports:
//   clk_50MHz  in   1  sole clock, rising edge
//   reset      in   1  synchronous, active-low reset
//   req        in   4  level note requests, one per button
//   abort      in   1  level, cuts the note currently playing short
//   buzzer     out  1  square-wave tone to the piezo
//   grant      out  4  one-hot index of the note playing, 0 outside PLAY
//   busy       out  1  high whenever the scheduler is not idle
//   note_done  out  1  one-cycle pulse when a note ends
// -----------------------------------------------------------------------------
module tone_scheduler #(
  parameter int NOTE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int HP0         = 95555,
  parameter int HP1         = 90194,
  parameter int HP2         = 50619,
  parameter int HP3         = 47778
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       abort,
  output logic       buzzer,
  output logic [3:0] grant,
  output logic       busy,
  output logic       note_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Counters count down to zero from (length - 1), so a phase of length N
  // occupies exactly N cycles.
  localparam logic [24:0] NOTE_LOAD = 25'(NOTE_CYCLES - 1);
  localparam logic [24:0] GAP_LOAD  = 25'(GAP_CYCLES - 1);

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  req_q_r;
  logic [3:0]  pending_r;
  logic [3:0]  rise_s;
  logic [3:0]  pick_s;
  logic [3:0]  clr_s;
  logic [24:0] dur_r;
  logic [24:0] tone_r;

  // Reload value of the tone counter for a one-hot requester.
  function automatic logic [24:0] hp_load(input logic [3:0] onehot);
    logic [24:0] hp;
    case (onehot)
      4'b0001: hp = 25'(HP0 - 1);
      4'b0010: hp = 25'(HP1 - 1);
      4'b0100: hp = 25'(HP2 - 1);
      4'b1000: hp = 25'(HP3 - 1);
      default: hp = 25'd0;
    endcase
    return hp;
  endfunction

`ifdef TONE_SCHED_RR_EN
  logic [1:0] rr_ptr_r;

  // First pending bit found searching upward from the one after last.
  function automatic logic [3:0] pick_rr(input logic [3:0] p, input logic [1:0] last);
    logic [3:0] g;
    logic [1:0] idx;
    logic       found;
    g     = 4'b0000;
    found = 1'b0;
    for (int i = 1; i < 5; i++) begin
      idx = last + i[1:0];
      if (!found && p[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end else begin
        found = found;
      end
    end
    return g;
  endfunction

  function automatic logic [1:0] encode(input logic [3:0] onehot);
    logic [1:0] e;
    case (onehot)
      4'b0010: e = 2'd1;
      4'b0100: e = 2'd2;
      4'b1000: e = 2'd3;
      default: e = 2'd0;
    endcase
    return e;
  endfunction

  // Round-robin choice among pending requests.
  always_comb begin
    pick_s = pick_rr(pending_r, rr_ptr_r);
  end

  // Pointer remembers the last granted index; moves only on a grant.
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      rr_ptr_r <= 2'd3;
    end else if (state_r == ARB && pick_s != 4'b0000) begin
      rr_ptr_r <= encode(pick_s);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  function automatic logic [3:0] pick_fixed(input logic [3:0] p);
    logic [3:0] g;
    if (p[0]) begin
      g = 4'b0001;
    end else if (p[1]) begin
      g = 4'b0010;
    end else if (p[2]) begin
      g = 4'b0100;
    end else if (p[3]) begin
      g = 4'b1000;
    end else begin
      g = 4'b0000;
    end
    return g;
  endfunction

  // Fixed-priority choice among pending requests.
  always_comb begin
    pick_s = pick_fixed(pending_r);
  end
`endif

  // Edge detect and grant-clear terms for the pending register.
  always_comb begin
    rise_s = req & ~req_q_r;
    if (state_r == ARB) begin
      clr_s = pick_s;
    end else begin
      clr_s = 4'b0000;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pending_r != 4'b0000) begin
          next_state_s = ARB;
        end else begin
          next_state_s = IDLE;
        end
      end
      ARB: begin
        next_state_s = PLAY;
      end
      PLAY: begin
        if (abort || dur_r == 25'd0) begin
          next_state_s = GAP;
        end else begin
          next_state_s = PLAY;
        end
      end
      GAP: begin
        if (dur_r != 25'd0) begin
          next_state_s = GAP;
        end else if (pending_r != 4'b0000) begin
          next_state_s = ARB;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request queue, counters and registered outputs.
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      req_q_r   <= 4'b0000;
      pending_r <= 4'b0000;
      dur_r     <= 25'd0;
      tone_r    <= 25'd0;
      grant     <= 4'b0000;
      buzzer    <= 1'b0;
      busy      <= 1'b0;
      note_done <= 1'b0;
    end else begin
      req_q_r   <= req;
      // A new edge on the bit being granted keeps it queued (set wins).
      pending_r <= (pending_r & ~clr_s) | rise_s;
      busy      <= (next_state_s != IDLE);
      note_done <= (state_r == PLAY) && (next_state_s == GAP);

      if (next_state_s == PLAY && state_r != PLAY) begin
        dur_r  <= NOTE_LOAD;
        tone_r <= hp_load(pick_s);
        grant  <= pick_s;
        buzzer <= 1'b0;
      end else if (next_state_s == PLAY) begin
        // Staying in PLAY implies dur_r is non-zero, so no wrap.
        dur_r <= dur_r - 25'd1;
        if (tone_r == 25'd0) begin
          tone_r <= hp_load(grant);
          buzzer <= ~buzzer;
        end else begin
          tone_r <= tone_r - 25'd1;
        end
      end else if (next_state_s == GAP && state_r != GAP) begin
        dur_r  <= GAP_LOAD;
        tone_r <= 25'd0;
        grant  <= 4'b0000;
        buzzer <= 1'b0;
      end else if (next_state_s == GAP) begin
        dur_r  <= dur_r - 25'd1;
        tone_r <= 25'd0;
        grant  <= 4'b0000;
        buzzer <= 1'b0;
      end else begin
        dur_r  <= 25'd0;
        tone_r <= 25'd0;
        grant  <= 4'b0000;
        buzzer <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tone_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tone_scheduler
//
// Self-checking bench for tone_scheduler with short notes (20 cycles), a
// 4-cycle gap and half-periods 5/4/3/2. Directed scenarios check against
// hand-derived constants. A random phase compares every output each cycle
// with a timeline model kept in the bench. Define TONE_SCHED_RR_EN for both
// the DUT and the bench to exercise the round-robin build.
// -----------------------------------------------------------------------------
module tb_tone_scheduler;

  localparam int NOTE = 20;
  localparam int GAPC = 4;

  logic       clk_50MHz = 1'b0;
  logic       reset     = 1'b0;
  logic [3:0] req       = 4'b0000;
  logic       abort     = 1'b0;
  logic       buzzer;
  logic [3:0] grant;
  logic       busy;
  logic       note_done;

  int errors = 0;
  int checks = 0;

  // Observation log, filled by tick().
  logic [3:0] gq[$];
  int         nd_cnt = 0;
  logic [3:0] last_g = 4'b0000;

  // Reference model: phase (0 idle, 1 arb, 2 play, 3 gap), time in phase.
  logic [3:0] m_prev;
  logic [3:0] m_pend;
  int         m_mode;
  int         m_t;
  int         m_cur;
  int         m_last;
  logic       m_nd;

  always #5 clk_50MHz = ~clk_50MHz;

  tone_scheduler #(
    .NOTE_CYCLES(NOTE), .GAP_CYCLES(GAPC),
    .HP0(5), .HP1(4), .HP2(3), .HP3(2)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .req(req), .abort(abort),
    .buzzer(buzzer), .grant(grant), .busy(busy), .note_done(note_done)
  );

  function automatic int hp(input int k);
    case (k)
      0: return 5;
      1: return 4;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] p, input int last);
`ifdef TONE_SCHED_RR_EN
    for (int k = 1; k <= 4; k++) if (p[(last + k) % 4]) return (last + k) % 4;
`else
    for (int k = 0; k < 4; k++) if (p[k]) return k;
`endif
    return 0;
  endfunction

  task automatic model_step();
    logic [3:0] rise;
    if (!reset) begin
      m_prev = 4'b0000; m_pend = 4'b0000; m_mode = 0; m_t = 0;
      m_cur = 0; m_last = 3; m_nd = 1'b0;
    end else begin
      rise   = req & ~m_prev;
      m_prev = req;
      m_nd   = 1'b0;
      case (m_mode)
        0: if (m_pend != 4'b0000) m_mode = 1;
        1: begin
          m_cur = pick(m_pend, m_last);
          m_last = m_cur;
          m_pend[m_cur] = 1'b0;
          m_mode = 2; m_t = 0;
        end
        2: if (abort || m_t == NOTE - 1) begin m_mode = 3; m_t = 0; m_nd = 1'b1; end
           else m_t++;
        3: if (m_t == GAPC - 1) begin m_mode = (m_pend != 4'b0000) ? 1 : 0; m_t = 0; end
           else m_t++;
        default: m_mode = 0;
      endcase
      m_pend = m_pend | rise;
    end
  endtask

  // Expected {grant, busy, buzzer, note_done} from the model.
  function automatic logic [6:0] model_out();
    logic [3:0] g;
    logic       bz;
    g  = (m_mode == 2) ? 4'(1 << m_cur) : 4'b0000;
    bz = (m_mode == 2) ? (((m_t / hp(m_cur)) % 2) == 1) : 1'b0;
    return {g, (m_mode != 0), bz, m_nd};
  endfunction

  // One clock: advance model with the inputs the DUT sampled, log outputs.
  task automatic tick();
    @(posedge clk_50MHz);
    model_step();
    #1;
    if (grant != 4'b0000 && grant != last_g) gq.push_back(grant);
    last_g = grant;
    if (note_done === 1'b1) nd_cnt++;
  endtask

  task automatic run_until_idle(input int max, output bit timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < max; c++) begin
      tick();
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'b0000; abort = 1'b0;
    tick(); tick();
    checks++;
    if ({grant, busy, buzzer, note_done} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", {grant, busy, buzzer, note_done}, 7'b0);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_note();
    bit to;
    gq.delete(); nd_cnt = 0;
    req = 4'b0001; tick(); req = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL single_arb: grant=%b busy=%b expected 0000/1", grant, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL single_latency: grant=%b expected 0001", grant); end
    for (int i = 0; i < NOTE; i++) begin
      checks++;
      if (buzzer !== 1'(((i / 5) % 2)) || grant !== 4'b0001 || note_done !== 1'b0) begin
        errors++;
        $display("FAIL single_play t=%0d: buzzer=%b grant=%b nd=%b expected %0d/0001/0", i, buzzer, grant, note_done, (i / 5) % 2);
      end
      tick();
    end
    checks++;
    if (note_done !== 1'b1 || buzzer !== 1'b0 || grant !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL single_end: nd=%b bz=%b grant=%b busy=%b expected 1/0/0000/1", note_done, buzzer, grant, busy);
    end
    for (int g = 1; g < GAPC; g++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || note_done !== 1'b0 || buzzer !== 1'b0) begin
        errors++; $display("FAIL single_gap g=%0d: busy=%b nd=%b bz=%b expected 1/0/0", g, busy, note_done, buzzer);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b expected 0", busy); end
    run_until_idle(5, to);
    checks++;
    if (nd_cnt !== 1) begin errors++; $display("FAIL single_nd_count: got %0d expected 1", nd_cnt); end
  endtask

  task automatic test_all_four();
    logic [3:0] exp[5];
    bit pulsed, req_hi, done;
`ifdef TONE_SCHED_RR_EN
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b1000};
`endif
    gq.delete(); nd_cnt = 0; pulsed = 1'b0; req_hi = 1'b0; done = 1'b0;
    req = 4'b1111; tick(); req = 4'b0000;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      if (req_hi) begin
        req = 4'b0000; req_hi = 1'b0;
      end else if (!pulsed && grant == 4'b0100) begin
        req = 4'b1001; pulsed = 1'b1; req_hi = 1'b1;
      end
      if (c > 5 && busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL all_four_timeout: busy=%b expected 0", busy); end
    checks++;
    if (gq.size() != 5) begin errors++; $display("FAIL all_four_count: got %0d expected 5", gq.size()); end
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      checks++;
      if (gq[i] !== exp[i]) begin errors++; $display("FAIL all_four_order[%0d]: got %b expected %b", i, gq[i], exp[i]); end
    end
    checks++;
    if (nd_cnt !== 5) begin errors++; $display("FAIL all_four_nd: got %0d expected 5", nd_cnt); end
  endtask

  task automatic test_abort();
    bit to;
    gq.delete(); nd_cnt = 0;
    req = 4'b0010; tick(); req = 4'b0000; tick(); tick();
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL abort_grant: got %b expected 0010", grant); end
    tick(); req = 4'b0100; tick(); req = 4'b0000;
    repeat (4) tick();
    checks++;
    if (buzzer !== 1'b1) begin errors++; $display("FAIL abort_pre_buzzer: got %b expected 1", buzzer); end
    abort = 1'b1; tick();
    checks++;
    if (grant !== 4'b0000 || buzzer !== 1'b0 || note_done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_end: grant=%b bz=%b nd=%b busy=%b expected 0000/0/1/1", grant, buzzer, note_done, busy);
    end
    repeat (GAPC - 1) tick();
    checks++;
    if (grant !== 4'b0000 || note_done !== 1'b0) begin
      errors++; $display("FAIL abort_gap: grant=%b nd=%b expected 0000/0", grant, note_done);
    end
    tick();
    abort = 1'b0;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_arb: grant=%b busy=%b expected 0000/1", grant, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL abort_queued: grant=%b expected 0100", grant); end
    run_until_idle(100, to);
    checks++;
    if (to || nd_cnt !== 2 || gq.size() != 2) begin
      errors++; $display("FAIL abort_finish: timeout=%0d nd=%0d notes=%0d expected 0/2/2", to, nd_cnt, gq.size());
    end
  endtask

  task automatic test_regrant();
    bit to;
    gq.delete(); nd_cnt = 0;
    req = 4'b0100; tick(); req = 4'b0000; tick();
    req = 4'b0100; tick(); req = 4'b0000;
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL regrant_first: grant=%b expected 0100", grant); end
    run_until_idle(200, to);
    checks++;
    if (to || gq.size() != 2 || nd_cnt !== 2) begin
      errors++; $display("FAIL regrant_count: timeout=%0d notes=%0d nd=%0d expected 0/2/2", to, gq.size(), nd_cnt);
    end
    for (int i = 0; i < gq.size(); i++) begin
      checks++;
      if (gq[i] !== 4'b0100) begin errors++; $display("FAIL regrant_note[%0d]: got %b expected 0100", i, gq[i]); end
    end
  endtask

  task automatic test_reset_mid_play();
    req = 4'b0001; tick(); req = 4'b0000; tick(); tick();
    tick(); req = 4'b1010; tick(); req = 4'b0000;
    repeat (7) tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL rstmid_pre: grant=%b expected 0001", grant); end
    reset = 1'b0; tick();
    checks++;
    if ({grant, busy, buzzer, note_done} !== 7'b0) begin
      errors++; $display("FAIL rstmid_outputs: got %b expected %b", {grant, busy, buzzer, note_done}, 7'b0);
    end
    reset = 1'b1;
    gq.delete(); nd_cnt = 0;
    repeat (100) tick();
    checks++;
    if (gq.size() != 0 || nd_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: notes=%0d nd=%0d busy=%b expected 0/0/0", gq.size(), nd_cnt, busy);
    end
  endtask

  task automatic test_hold();
    bit to;
    gq.delete(); nd_cnt = 0;
    req = 4'b0010;
    repeat (100) tick();
    req = 4'b0000;
    run_until_idle(100, to);
    checks++;
    if (to || gq.size() != 1 || nd_cnt !== 1) begin
      errors++; $display("FAIL hold_count: timeout=%0d notes=%0d nd=%0d expected 0/1/1", to, gq.size(), nd_cnt);
    end
    if (gq.size() >= 1) begin
      checks++;
      if (gq[0] !== 4'b0010) begin errors++; $display("FAIL hold_grant: got %b expected 0010", gq[0]); end
    end
  endtask

  task automatic test_random();
    logic [6:0] exp;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      abort = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 600) != 0);
      tick();
      exp = model_out();
      checks++;
      if ({grant, busy, buzzer, note_done} !== exp) begin
        errors++; $display("FAIL random c=%0d: {grant,busy,buzzer,nd} got %b expected %b", c, {grant, busy, buzzer, note_done}, exp);
      end
    end
    req = 4'b0000; abort = 1'b0; reset = 1'b1;
    repeat (60) tick();
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_all_four();
    test_abort();
    test_regrant();
    test_reset_mid_play();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 The block SHALL have parameter NOTE_CYCLES, default 25000000, clk_50MHz cycles per note (0.5 s).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2500000, silent cycles between notes (50 ms).
REQ-003 The block SHALL have parameters HP0/HP1/HP2/HP3, defaults 95555/90194/50619/47778, half-periods in cycles for 261.63/277.18/493.88/523.25 Hz.
REQ-004 clk_50MHz  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req  input  4  debounced note requests, one per button, level.
REQ-007 abort  input  1  terminate current note, level.
REQ-008 buzzer  output  1  square-wave tone to the piezo.
REQ-009 grant  output  4  one-hot requester currently playing; 0 when not in PLAY.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 note_done  output  1  single-cycle pulse at the end of each PLAY.

Function
REQ-012 The block SHALL register req into req_q each cycle; a rising edge (req[i]=1, req_q[i]=0) SHALL set pending[i] on the next clock edge.
REQ-013 Pending bits SHALL accumulate in every state; holding req high SHALL NOT re-queue a note.
REQ-014 FSM states SHALL be IDLE, ARB, PLAY, GAP.
REQ-015 IDLE->ARB when pending!=0; ARB->PLAY after exactly 1 cycle, loading grant and clearing that pending bit.
REQ-016 If a rising edge on req[i] coincides with pending[i] being cleared by grant, set SHALL win and pending[i] SHALL remain 1.
REQ-017 PLAY SHALL last exactly NOTE_CYCLES cycles, then go to GAP with note_done=1 for one cycle.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles, then go to ARB if pending!=0, else to IDLE.
REQ-019 In PLAY, buzzer SHALL start at 0 on PLAY entry and toggle every HPk cycles, k = granted index; first toggle HPk cycles after entry.
REQ-020 buzzer SHALL be 0 in IDLE, ARB and GAP.
REQ-021 abort=1 in PLAY SHALL end PLAY on the next edge, entering GAP with note_done pulsed; abort SHALL be ignored in other states and SHALL NOT clear pending.
REQ-022 Duration and tone counters SHALL be 25 bits, SHALL reload on each state entry, and SHALL never wrap.
REQ-023 Latency: a req rising edge in IDLE SHALL produce PLAY/grant 3 cycles later (edge detect, ARB, PLAY).

Reset
REQ-024 With reset=0 at a clock edge: state=IDLE, pending=0, req_q=0, grant=0, buzzer=0, busy=0, note_done=0, counters=0, RR pointer=3.
REQ-025 Reset asserted mid-PLAY or mid-GAP SHALL discard the note and all pending requests with no note_done pulse.

Configuration
REQ-026 With TONE_SCHED_RR_EN defined, ARB SHALL grant round-robin, searching from (last granted index + 1) mod 4; pointer updates on grant only.
REQ-027 Without TONE_SCHED_RR_EN, ARB SHALL use fixed priority, req[0] highest, req[3] lowest; no pointer register.

Verification (NOTE_CYCLES=20, GAP_CYCLES=4, HP0..HP3=5/4/3/2)
REQ-028 Pulse req[0] in IDLE -> grant=0001 3 cycles later, buzzer toggles every 5 cycles for 20 cycles, note_done once, 4 silent cycles, back to IDLE, busy=0.
REQ-029 req=1111 rising in same cycle -> RR build: grants 0001,0010,0100,1000; non-RR build: same order. Then re-pulse req[0] and req[3] during grant 0100 -> RR: 1000 then 0001; non-RR: 0001 then 1000.
REQ-030 abort=1 on cycle 7 of PLAY -> PLAY ends next edge, buzzer=0, note_done pulse, GAP 4 cycles, queued request still served.
REQ-031 Re-pulse req[2] on the exact cycle it is granted -> pending[2] stays 1; note 2 plays twice back-to-back.
REQ-032 reset=0 during PLAY cycle 10 with pending=1010 -> all outputs 0 next edge, IDLE, no notes after reset release.
REQ-033 Hold req[1] high for 100 cycles -> exactly one note played.
